// File: rtl/deque_pkg.sv
// Shared types and the request-acceptance rule for the double-ended queue.
package deque_pkg;

  localparam int DEF_AWIDTH = 8;

  typedef logic [DEF_AWIDTH-1:0] ptr_t;
  typedef logic [DEF_AWIDTH:0]   cnt_t;

  typedef struct packed {
    logic push_front;
    logic push_back;
    logic pop_front;
    logic pop_back;
  } acc_t;

  // Acceptance is judged on start-of-cycle occupancy only; when just one slot
  // (or one entry) is available, the front request wins.
  function automatic acc_t accept(input int used, input int depth,
                                  input logic pf, input logic pb,
                                  input logic pof, input logic pob);
    acc_t a;
    int   free;
    free         = depth - used;
    a.push_front = pf && (free >= 1);
    a.push_back  = pb && ((free >= 2) || ((free == 1) && !pf));
    a.pop_front  = pof && (used >= 1);
    a.pop_back   = pob && ((used >= 2) || ((used == 1) && !pof));
    return a;
  endfunction

endpackage

// File: rtl/deque_regfile.sv
// Storage array: two write ports, two asynchronous read ports returning pre-write data.
module deque_regfile #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              we_a_i,
  input  logic [AWIDTH-1:0] wa_a_i,
  input  logic [DWIDTH-1:0] wd_a_i,
  input  logic              we_b_i,
  input  logic [AWIDTH-1:0] wa_b_i,
  input  logic [DWIDTH-1:0] wd_b_i,
  input  logic [AWIDTH-1:0] ra_a_i,
  output logic [DWIDTH-1:0] rd_a_o,
  input  logic [AWIDTH-1:0] ra_b_i,
  output logic [DWIDTH-1:0] rd_b_o
);

  logic [DWIDTH-1:0] mem_q [2**AWIDTH];

  // The two write addresses never coincide for accepted requests.
  always_ff @(posedge clk_i) begin
    if (we_a_i) mem_q[wa_a_i] <= wd_a_i;
    if (we_b_i) mem_q[wa_b_i] <= wd_b_i;
  end

  assign rd_a_o = mem_q[ra_a_i];
  assign rd_b_o = mem_q[ra_b_i];

endmodule

// File: rtl/deque.sv
// Double-ended queue over a circular buffer: push/pop at both ends, registered pop data.
module deque
  import deque_pkg::*;
#(
  parameter int DWIDTH       = 16,
  parameter int AWIDTH       = 8,
  parameter int ALMOST_FULL  = 2,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              push_front_i,
  input  logic [DWIDTH-1:0] data_front_i,
  input  logic              push_back_i,
  input  logic [DWIDTH-1:0] data_back_i,
  input  logic              pop_front_i,
  input  logic              pop_back_i,
  output logic [DWIDTH-1:0] q_front_o,
  output logic [DWIDTH-1:0] q_back_o,
  output logic              empty_o,
  output logic              almost_empty_o,
  output logic              almost_full_o,
  output logic              full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              drop_o
);

  localparam int DEPTH = 2**AWIDTH;

  logic [AWIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [AWIDTH-1:0] wa_front, wa_back, ra_back;
  logic [AWIDTH:0]   usedw_q, usedw_d;
  logic [DWIDTH-1:0] qf_q, qb_q, rd_front, rd_back;
  logic              drop_q, drop_d;
  acc_t              acc;

  always_comb begin
    acc      = accept(int'(usedw_q), DEPTH, push_front_i, push_back_i,
                      pop_front_i, pop_back_i);
    head_d   = head_q + AWIDTH'(acc.pop_front) - AWIDTH'(acc.push_front);
    tail_d   = tail_q + AWIDTH'(acc.push_back) - AWIDTH'(acc.pop_back);
    // Push+pop on one end overwrites that end's slot in place.
    wa_front = head_d;
    wa_back  = tail_q - AWIDTH'(acc.pop_back);
    ra_back  = tail_q - AWIDTH'(1);
    usedw_d  = usedw_q + (AWIDTH+1)'(acc.push_front) + (AWIDTH+1)'(acc.push_back)
                       - (AWIDTH+1)'(acc.pop_front)  - (AWIDTH+1)'(acc.pop_back);
    drop_d   = (push_front_i & ~acc.push_front) | (push_back_i & ~acc.push_back) |
               (pop_front_i  & ~acc.pop_front)  | (pop_back_i  & ~acc.pop_back);
  end

  deque_regfile #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_regfile (
    .clk_i  (clk_i),
    .we_a_i (acc.push_front & ~srst_i),
    .wa_a_i (wa_front),
    .wd_a_i (data_front_i),
    .we_b_i (acc.push_back & ~srst_i),
    .wa_b_i (wa_back),
    .wd_b_i (data_back_i),
    .ra_a_i (head_q),
    .rd_a_o (rd_front),
    .ra_b_i (ra_back),
    .rd_b_o (rd_back)
  );

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      usedw_q <= '0;
      qf_q    <= '0;
      qb_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      usedw_q <= usedw_d;
      drop_q  <= drop_d;
      if (acc.pop_front) qf_q <= rd_front;
      if (acc.pop_back)  qb_q <= rd_back;
    end
  end

  assign q_front_o      = qf_q;
  assign q_back_o       = qb_q;
  assign usedw_o        = usedw_q;
  assign drop_o         = drop_q;
  assign empty_o        = (usedw_q == '0);
  assign full_o         = (usedw_q == (AWIDTH+1)'(DEPTH));
  assign almost_empty_o = (usedw_q <= (AWIDTH+1)'(ALMOST_EMPTY));
  assign almost_full_o  = (usedw_q >= (AWIDTH+1)'(DEPTH - ALMOST_FULL));

endmodule

// File: tb/tb_deque.sv
// Self-checking bench for deque: queue-based reference model plus directed corner cases.
module tb_deque;
  localparam int DW = 16, AW = 8, DEPTH = 256;

  logic          clk = 1'b0;
  logic          srst, push_front, push_back, pop_front, pop_back;
  logic [DW-1:0] data_front, data_back;
  logic [DW-1:0] q_front, q_back;
  logic          empty, almost_empty, almost_full, full, drop;
  logic [AW:0]   usedw;

  deque #(.DWIDTH(DW), .AWIDTH(AW), .ALMOST_FULL(2), .ALMOST_EMPTY(2)) dut (
    .clk_i(clk), .srst_i(srst),
    .push_front_i(push_front), .data_front_i(data_front),
    .push_back_i(push_back), .data_back_i(data_back),
    .pop_front_i(pop_front), .pop_back_i(pop_back),
    .q_front_o(q_front), .q_back_o(q_back),
    .empty_o(empty), .almost_empty_o(almost_empty),
    .almost_full_o(almost_full), .full_o(full),
    .usedw_o(usedw), .drop_o(drop)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, front at index 0.
  logic [DW-1:0] dq[$];
  logic [DW-1:0] exp_qf = '0, exp_qb = '0;
  logic          exp_drop = 1'b0;
  bit            chk_en = 1'b0;
  int            nchecks = 0, nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    int n;
    if (chk_en) begin
      n = dq.size();
      chk("usedw", 32'(usedw), n);
      chk("q_front", 32'(q_front), 32'(exp_qf));
      chk("q_back", 32'(q_back), 32'(exp_qb));
      chk("drop", 32'(drop), 32'(exp_drop));
      chk("empty", 32'(empty), 32'(n == 0));
      chk("full", 32'(full), 32'(n == DEPTH));
      chk("almost_empty", 32'(almost_empty), 32'(n <= 2));
      chk("almost_full", 32'(almost_full), 32'(n >= DEPTH - 2));
    end
  end

  // Drive one cycle of requests, advance the model at the edge, return at the next negedge.
  task automatic step(input logic rst, input logic pf, input logic [DW-1:0] df,
                      input logic pb, input logic [DW-1:0] db,
                      input logic pof, input logic pob);
    int  n, free;
    bit  apf, apb, apof, apob;
    srst = rst; push_front = pf; data_front = df; push_back = pb; data_back = db;
    pop_front = pof; pop_back = pob;
    @(posedge clk);
    if (rst) begin
      dq.delete();
      exp_qf = '0; exp_qb = '0; exp_drop = 1'b0;
    end else begin
      n    = dq.size();
      free = DEPTH - n;
      apf  = pf && free >= 1;
      apb  = pb && (free >= 2 || (free == 1 && !pf));
      apof = pof && n >= 1;
      apob = pob && (n >= 2 || (n == 1 && !pof));
      exp_drop = (pf && !apf) || (pb && !apb) || (pof && !apof) || (pob && !apob);
      if (apof) exp_qf = dq.pop_front();
      if (apob) exp_qb = dq.pop_back();
      if (apf) dq.push_front(df);
      if (apb) dq.push_back(db);
    end
    @(negedge clk);
  endtask

  task automatic idle();            step(0, 0, '0, 0, '0, 0, 0); endtask
  task automatic reset();           step(1, 0, '0, 0, '0, 0, 0); endtask
  task automatic pushb(input logic [DW-1:0] d); step(0, 0, '0, 1, d, 0, 0); endtask
  task automatic popf();            step(0, 0, '0, 0, '0, 1, 0); endtask
  task automatic popb();            step(0, 0, '0, 0, '0, 0, 1); endtask

  initial begin
    int bias;
    bit rst, pf, pb, pof, pob;
    srst = 1'b1; push_front = 0; push_back = 0; pop_front = 0; pop_back = 0;
    data_front = '0; data_back = '0;
    @(negedge clk);
    reset(); reset();
    chk_en = 1'b1;
    chk("rst_usedw", 32'(usedw), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_q", 32'({q_front, q_back}), 0);

    // LIFO: reverse order, full after 256 pushes
    for (int i = 0; i < 256; i++) pushb(DW'(i));
    chk("lifo_full", 32'(full), 1);
    chk("lifo_usedw", 32'(usedw), 256);
    popb();
    chk("lifo_first", 32'(q_back), 32'h00ff);
    for (int i = 1; i < 256; i++) popb();
    chk("lifo_last", 32'(q_back), 0);
    chk("lifo_empty", 32'(empty), 1);

    // FIFO order and almost_full threshold, then over/underflow drops
    for (int i = 0; i < 256; i++) begin
      pushb(DW'(16'h100 + i));
      if (i == 252) chk("af_253", 32'(almost_full), 0);
      if (i == 253) chk("af_254", 32'(almost_full), 1);
    end
    pushb(16'hdead);
    chk("ovf_drop", 32'(drop), 1);
    chk("ovf_usedw", 32'(usedw), 256);
    idle();
    chk("drop_pulse", 32'(drop), 0);
    popf();
    chk("fifo_first", 32'(q_front), 32'h0100);
    for (int i = 1; i < 256; i++) popf();
    chk("fifo_last", 32'(q_front), 32'h01ff);
    popf();
    chk("udf_drop", 32'(drop), 1);
    chk("udf_usedw", 32'(usedw), 0);
    chk("udf_qf", 32'(q_front), 32'h01ff);

    // One entry, both pops: only the front pop wins
    pushb(16'h00a1);
    step(0, 0, '0, 0, '0, 1, 1);
    chk("pop2_qf", 32'(q_front), 32'h00a1);
    chk("pop2_drop", 32'(drop), 1);
    chk("pop2_usedw", 32'(usedw), 0);

    // One free slot, both pushes: only the front push wins
    for (int i = 0; i < 255; i++) pushb(DW'(i));
    step(0, 1, 16'hf00d, 1, 16'h1234, 0, 0);
    chk("push2_usedw", 32'(usedw), 256);
    chk("push2_drop", 32'(drop), 1);
    popf();
    chk("push2_front", 32'(q_front), 32'hf00d);

    // Same-end pop+push swaps the front element
    reset();
    for (int i = 0; i < 5; i++) pushb(DW'(16'h50 + i));
    step(0, 1, 16'hbeef, 0, '0, 1, 0);
    chk("swap_old", 32'(q_front), 32'h0050);
    chk("swap_usedw", 32'(usedw), 5);
    popf();
    chk("swap_new", 32'(q_front), 32'hbeef);

    // Random traffic with drifting push/pop bias and a mid-run reset
    bias = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) bias = $urandom_range(10, 90);
      rst = (c == 5000) || ($urandom_range(0, 2999) == 0);
      pf  = $urandom_range(0, 99) < bias / 2;
      pb  = $urandom_range(0, 99) < bias / 2;
      pof = $urandom_range(0, 99) < (100 - bias) / 2;
      pob = $urandom_range(0, 99) < (100 - bias) / 2;
      step(rst, pf, DW'($urandom), pb, DW'($urandom), pof, pob);
      if (c == 5000) begin
        chk("mid_rst_usedw", 32'(usedw), 0);
        chk("mid_rst_q", 32'({q_front, q_back}), 0);
        chk("mid_rst_flags", 32'({empty, almost_empty, full, almost_full, drop}), 32'b11000);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/deque.md
DEQUE -- requirements
Module: deque

Interface
REQ-001 Parameter DWIDTH, default 16: data word width in bits.
REQ-002 Parameter AWIDTH, default 8: address width; DEPTH = 2**AWIDTH entries.
REQ-003 Parameter ALMOST_FULL, default 2: almost_full_o threshold, as free slots remaining.
REQ-004 Parameter ALMOST_EMPTY, default 2: almost_empty_o threshold, as used entries.
REQ-005 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-006 srst_i  in  1  reset; synchronous, active-high.
REQ-007 push_front_i  in  1  write data_front_i at the front end.
REQ-008 data_front_i  in  DWIDTH  front-end write data.
REQ-009 push_back_i  in  1  write data_back_i at the back end.
REQ-010 data_back_i  in  DWIDTH  back-end write data.
REQ-011 pop_front_i  in  1  remove the front element.
REQ-012 pop_back_i  in  1  remove the back element.
REQ-013 q_front_o  out  DWIDTH  last element popped from the front (registered).
REQ-014 q_back_o  out  DWIDTH  last element popped from the back (registered).
REQ-015 empty_o, almost_empty_o, almost_full_o, full_o  out  1 each  occupancy flags.
REQ-016 usedw_o  out  AWIDTH+1  number of stored entries, 0..DEPTH.
REQ-017 drop_o  out  1  one-cycle pulse: at least one push or pop was rejected this cycle.

Function
REQ-018 Storage: circular buffer of DEPTH words; head points at the front element; tail points one past the back element; pointers wrap modulo DEPTH.
REQ-019 Accept pushes against start-of-cycle usedw only: free = DEPTH-usedw; both pushes accepted if free>=2; if free==1, only push_front accepted; if free==0, both rejected.
REQ-020 Accept pops against start-of-cycle usedw only: both pops accepted if usedw>=2; if usedw==1, only pop_front accepted; if usedw==0, both rejected.
REQ-021 Same-cycle pops do not free space for same-cycle pushes; same-cycle pushes do not supply data for same-cycle pops.
REQ-022 Accepted push_front: head <= head-1, then write mem[new head]. Accepted push_back: write mem[tail], tail <= tail+1.
REQ-023 Accepted pop_front: q_front_o <= mem[head] (pre-write value), head <= head+1. Accepted pop_back: q_back_o <= mem[tail-1], tail <= tail-1.
REQ-024 Simultaneous accepted pop and push on the same end: pop returns the old element; the new data becomes that end's element; the pointer for that end is unchanged.
REQ-025 Read latency: q_front_o and q_back_o are valid on the cycle after the pop request; each holds its value until its next accepted pop.
REQ-026 usedw_o <= usedw_o + accepted pushes - accepted pops; it is a register.
REQ-027 Flags are derived from usedw_o: empty_o = (usedw_o==0); full_o = (usedw_o==DEPTH); almost_empty_o = (usedw_o<=ALMOST_EMPTY); almost_full_o = (usedw_o>=DEPTH-ALMOST_FULL).
REQ-028 drop_o is registered and asserts the cycle after any rejected request.
REQ-029 LIFO use = push_back/pop_back only; FIFO use = push_back/pop_front only; both behave exactly as the dedicated blocks do.

Reset
REQ-030 While srst_i=1: head=0, tail=0, usedw_o=0, q_front_o=0, q_back_o=0, drop_o=0, empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0.
REQ-031 srst_i overrides all requests in the same cycle; memory contents are not cleared.

Structure
REQ-032 The package deque_pkg holds the pointer/count typedefs and a function computing accepted-request counts from usedw and the request bits.
REQ-033 The array sits in one sub-module, deque_regfile: two write ports and two read ports; reads return pre-write contents.

Verification
REQ-034 Reset, then 256 push_back, then 256 pop_back -> q_back_o returns values in reverse order; full_o=1 after the 256th push; usedw_o ends at 0 with empty_o=1.
REQ-035 256 push_back, then 256 pop_front -> q_front_o returns values in push order; almost_full_o asserts at usedw_o=254.
REQ-036 Full buffer plus push_back, then empty buffer plus pop_front -> drop_o pulses one cycle each time; usedw_o stays at 256 and 0 respectively; q_front_o is unchanged.
REQ-037 usedw_o=1 with pop_front and pop_back both asserted -> only the front pop is accepted; drop_o=1; usedw_o=0. usedw_o=255 with both pushes asserted -> only push_front is accepted.
REQ-038 usedw_o=5 with pop_front+push_front (data 0xBEEF) -> q_front_o is the old front value; usedw_o stays 5; the next pop_front returns 0xBEEF.
REQ-039 10000 cycles of random requests against a queue reference model -> every q output and usedw_o match; srst_i asserted mid-run restores all REQ-030 values.
